// File: rtl/integrator_rr_scheduler.sv
// Round-robin scheduler that shares one integrate-and-dump adder among NCH sample streams.
// Define INTEGRATOR_SAT_EN for saturating adds; the default build wraps modulo 2^AW.
module integrator_rr_scheduler #(
  parameter int NCH      = 4,
  parameter int DW       = 10,
  parameter int AW       = 16,
  parameter int DUMP_LEN = 8,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_ch,
  output logic [AW-1:0]     out_data,
  output logic              busy
);

  localparam int            NW       = $clog2(DUMP_LEN + 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(DUMP_LEN - 1);
  localparam logic [CW:0]   NCH_W    = (CW+1)'(NCH);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DUMP} op_e;

  logic [AW-1:0]  acc_reg [NCH];
  logic [NW-1:0]  cnt_reg [NCH];
  logic [CW-1:0]  rr_ptr_reg;

  logic           can_go;
  logic           grant_any;
  logic [CW-1:0]  grant_ch;
  logic [CW:0]    probe;
  logic [NCH-1:0] cnt_nz;
  logic [DW-1:0]  sample;
  logic [AW-1:0]  sample_ext;
  logic [AW-1:0]  acc_sel;
  logic [AW-1:0]  acc_sum;
  op_e            op;
`ifdef INTEGRATOR_SAT_EN
  logic [AW:0]    wide_sum;
`endif

  // Scan from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    can_go    = !out_valid || out_ready;
    grant_any = 1'b0;
    grant_ch  = '0;
    probe     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      probe = {1'b0, rr_ptr_reg} + (CW+1)'(k);
      if (probe >= NCH_W) probe = probe - NCH_W;
      if (req_valid[probe[CW-1:0]]) begin
        grant_any = 1'b1;
        grant_ch  = probe[CW-1:0];
      end
    end
    grant_any = grant_any && can_go && system1000_rstn;
    req_ready = '0;
    if (grant_any) req_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    sample     = req_data[grant_ch*DW +: DW];
    sample_ext = AW'($signed(sample));
    acc_sel    = acc_reg[grant_ch];
`ifdef INTEGRATOR_SAT_EN
    // One extra bit exposes overflow; clamp toward the sign of the true sum.
    wide_sum = {acc_sel[AW-1], acc_sel} + {sample_ext[AW-1], sample_ext};
    if (wide_sum[AW] != wide_sum[AW-1])
      acc_sum = wide_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      acc_sum = wide_sum[AW-1:0];
`else
    acc_sum = acc_sel + sample_ext;
`endif
    op = ST_IDLE;
    if (grant_any) op = (cnt_reg[grant_ch] == CNT_LAST) ? ST_DUMP : ST_ACC;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < NCH; i++) begin
        acc_reg[i] <= '0;
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (grant_ch == CW'(i)) begin
          if (op == ST_DUMP) begin
            acc_reg[i] <= '0;
            cnt_reg[i] <= '0;
          end else if (op == ST_ACC) begin
            acc_reg[i] <= acc_sum;
            cnt_reg[i] <= cnt_reg[i] + 1'b1;
          end
        end
      end
    end
  end

  // A DUMP is only granted when the output slot is free or being popped, so it may overwrite.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      rr_ptr_reg <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
    end else begin
      if (grant_any) rr_ptr_reg <= (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
      if (op == ST_DUMP) begin
        out_valid <= 1'b1;
        out_ch    <= grant_ch;
        out_data  <= acc_sum;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_busy
    assign cnt_nz[gi] = (cnt_reg[gi] != '0);
  end

  assign busy = out_valid || (|cnt_nz);

endmodule

// File: tb/tb_integrator_rr_scheduler.sv
// Scoreboard bench for integrator_rr_scheduler: a transaction-level model predicts grants and
// results; a second instance (AW=12, DUMP_LEN=16) exercises wrap/saturation.
`timescale 1ns/1ps
module tb_integrator_rr_scheduler;
  localparam int NCH = 4, DW = 10, AW = 16, DUMP_LEN = 4, CW = 2;
  localparam int AW2 = 12, DL2 = 16;

  typedef struct {int ch; longint data;} exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req_valid, req_ready;
  logic [NCH*DW-1:0] req_data;
  logic              out_valid, out_ready, busy;
  logic [CW-1:0]     out_ch;
  logic [AW-1:0]     out_data;

  logic [NCH-1:0]    req_valid2, req_ready2;
  logic [NCH*DW-1:0] req_data2;
  logic              out_valid2, out_ready2, busy2;
  logic [CW-1:0]     out_ch2;
  logic [AW2-1:0]    out_data2;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t q2[$];

  integrator_rr_scheduler #(.NCH(NCH), .DW(DW), .AW(AW), .DUMP_LEN(DUMP_LEN)) dut (
    .system1000(clk), .system1000_rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .busy(busy));

  integrator_rr_scheduler #(.NCH(NCH), .DW(DW), .AW(AW2), .DUMP_LEN(DL2)) dut_ovf (
    .system1000(clk), .system1000_rstn(rstn),
    .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_ch(out_ch2),
    .out_data(out_data2), .busy(busy2));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One spec-level add: either clamp to the signed AW range or reduce modulo 2^aw.
  function automatic longint fold(input longint a, input longint s, input int aw);
    longint r, hi, lo, m;
    m  = longint'(1) <<< aw;
    hi = (m >>> 1) - 1;
    lo = -(m >>> 1);
    r  = a + s;
`ifdef INTEGRATOR_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = r & (m - 1);
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  function automatic logic [NCH*DW-1:0] one_ch(input int ch, input int val);
    logic [NCH*DW-1:0] d;
    d = '0;
    d[ch*DW +: DW] = DW'(val);
    return d;
  endfunction

  function automatic logic [NCH*DW-1:0] rnd_data();
    return (NCH*DW)'({$urandom(), $urandom()});
  endfunction

  task automatic drive(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d, input logic ordy);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
  endtask

  // Reference model: per-channel running sums and sample counts, a round-robin pointer and an
  // output-slot-occupied flag, stepped once per cycle with the inputs that precede the edge.
  initial begin : model
    longint acc[NCH];
    int     cnt[NCH];
    int     ptr, g, idx;
    bit     pend, can_go, dump, anyp;
    longint s, exp_rdy;
    ptr = 0; pend = 0;
    for (int c = 0; c < NCH; c++) begin acc[c] = 0; cnt[c] = 0; end
    forever begin
      @(negedge clk); #1;
      if (!rstn) begin
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_data", longint'(out_data), 0);
        ptr = 0; pend = 0;
        for (int c = 0; c < NCH; c++) begin acc[c] = 0; cnt[c] = 0; end
        q.delete();
      end else begin
        can_go = !pend || out_ready;
        g = -1;
        if (can_go) begin
          for (int k = 0; k < NCH; k++) begin
            idx = (ptr + k) % NCH;
            if (req_valid[idx] && g < 0) g = idx;
          end
        end
        exp_rdy = (g >= 0) ? (longint'(1) << g) : 0;
        chk("req_ready", longint'(req_ready), exp_rdy);
        chk("out_valid", longint'(out_valid), longint'(pend));
        anyp = pend;
        for (int c = 0; c < NCH; c++) if (cnt[c] != 0) anyp = 1;
        chk("busy", longint'(busy), longint'(anyp));
        dump = 0;
        if (g >= 0) begin
          s = longint'($signed(req_data[g*DW +: DW]));
          acc[g] = fold(acc[g], s, AW);
          cnt[g]++;
          ptr = (g + 1) % NCH;
          if (cnt[g] == DUMP_LEN) begin
            q.push_back('{g, acc[g]});
            acc[g] = 0;
            cnt[g] = 0;
            dump = 1;
          end
        end
        if (dump) pend = 1;
        else if (out_ready) pend = 0;
      end
    end
  end

  // Monitor: compares every presented result (including stalled cycles) against the queue head.
  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      if (rstn && out_valid) begin
        if (q.size() == 0) chk("unexpected_result", longint'(out_valid), 0);
        else begin
          chk("out_ch", longint'(out_ch), longint'(q[0].ch));
          chk("out_data", longint'($signed(out_data)), q[0].data);
          if (out_ready) begin
            $display("result ch=%0d data=%0d", out_ch, $signed(out_data));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin : monitor_ovf
    forever begin
      @(negedge clk); #1;
      if (rstn && out_valid2) begin
        if (q2.size() == 0) chk("ovf_unexpected_result", longint'(out_valid2), 0);
        else begin
          chk("ovf_out_ch", longint'(out_ch2), longint'(q2[0].ch));
          chk("ovf_out_data", longint'($signed(out_data2)), q2[0].data);
          if (out_ready2) begin
            $display("ovf result ch=%0d data=%0d", out_ch2, $signed(out_data2));
            void'(q2.pop_front());
          end
        end
      end
    end
  end

  initial begin : driver
    longint a2;
    logic [NCH*DW-1:0] fair;
    req_valid = '0; req_data = '0; out_ready = 1'b1;
    req_valid2 = '0; req_data2 = '0; out_ready2 = 1'b1;

    // Reset with every channel requesting.
    repeat (3) drive(4'hF, rnd_data(), 1'b1);
    rstn = 1'b1;

    // Single channel: ch2 sends 1,2,3,4.
    for (int i = 1; i <= 4; i++) drive(4'b0100, one_ch(2, i), 1'b1);
    repeat (3) drive(4'b0000, '0, 1'b1);

    // Fairness: all channels valid with data = ch+1.
    fair = '0;
    for (int c = 0; c < NCH; c++) fair[c*DW +: DW] = DW'(c + 1);
    repeat (16) drive(4'hF, fair, 1'b1);
    repeat (4) drive(4'b0000, '0, 1'b1);

    // Backpressure: consumer mostly stalled, then drain.
    repeat (150) drive(4'hF, rnd_data(), ($urandom_range(0, 3) == 0));
    repeat (10) drive(4'b0000, '0, 1'b1);

    // Random traffic.
    repeat (500) drive(NCH'($urandom()), rnd_data(), ($urandom_range(0, 3) != 0));
    repeat (10) drive(4'b0000, '0, 1'b1);

    // Reset mid-operation discards ch0's partial sum.
    repeat (2) drive(4'b0001, one_ch(0, 5), 1'b1);
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    req_valid = 4'b0001;
    req_data = one_ch(0, 1);
    repeat (3) drive(4'b0001, one_ch(0, 1), 1'b1);
    repeat (4) drive(4'b0000, '0, 1'b1);

    // Overflow instance: ch1 sends 16x +511, then 16x -512.
    a2 = 0;
    for (int i = 0; i < DL2; i++) a2 = fold(a2, 511, AW2);
    q2.push_back('{1, a2});
    a2 = 0;
    for (int i = 0; i < DL2; i++) a2 = fold(a2, -512, AW2);
    q2.push_back('{1, a2});
    for (int i = 0; i < 2 * DL2; i++) begin
      @(negedge clk);
      req_valid2 = 4'b0010;
      req_data2  = one_ch(1, (i < DL2) ? 511 : 512);
    end
    @(negedge clk);
    req_valid2 = '0;
    repeat (4) @(negedge clk);

    #2;
    chk("main_queue_drained", longint'(q.size()), 0);
    chk("ovf_queue_drained", longint'(q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
